// File: rtl/obstacle_scroller.sv
// Single scrolling obstacle: spawns at the right edge with an LFSR-chosen gap, steps left per frame tick, counts passes.
// Optional DIFFICULTY_RAMP_EN: speed and gap follow the pass count (level = min(pass_count>>3, 3)).
module obstacle_scroller #(
  parameter int SPAWN_X = 159,
  parameter int Y_MIN   = 8,
  parameter int GAP_H   = 40,
  parameter int OBS_W   = 12,
  parameter int SPEED   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       freeze,
  input  logic       frame_tick,
  output logic [7:0] obstacles_x,
  output logic [6:0] obstacles_y,
  output logic [7:0] height,
  output logic [4:0] width,
  output logic       check_en,
  output logic       obstacle_valid,
  output logic [7:0] pass_count
);

  typedef enum logic [1:0] {IDLE, SPAWN, MOVE} state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [7:0] speed;
  logic [7:0] gap;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

`ifdef DIFFICULTY_RAMP_EN
  logic [1:0] level;
  always_comb begin
    // pass_count >= 32 always saturates; below that bits [4:3] are pass_count>>3.
    level = (|pass_count[7:5]) ? 2'd3 : pass_count[4:3];
    speed = 8'(SPEED) + {6'd0, level};
    gap   = 8'(GAP_H) - {5'd0, level, 1'b0};
  end
`else
  assign speed = 8'(SPEED);
  assign gap   = 8'(GAP_H);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lfsr           <= 8'hA5;
      obstacles_x    <= 8'(SPAWN_X);
      obstacles_y    <= 7'(Y_MIN);
      height         <= 8'(GAP_H);
      width          <= 5'(OBS_W);
      check_en       <= 1'b0;
      obstacle_valid <= 1'b0;
      pass_count     <= 8'd0;
    end else begin
      check_en <= 1'b0;
      if (stop) begin
        state          <= IDLE;
        obstacle_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !freeze) begin
              pass_count <= 8'd0;
              state      <= SPAWN;
            end
          end
          SPAWN: begin
            obstacles_x    <= 8'(SPAWN_X);
            obstacles_y    <= 7'(Y_MIN) + {1'b0, lfsr[5:0]};
            lfsr           <= {lfsr[6:0], lfsr_fb};
            height         <= gap;
            obstacle_valid <= 1'b1;
            check_en       <= 1'b1;
            state          <= MOVE;
          end
          MOVE: begin
            if (frame_tick && !freeze) begin
              // The respawn tick leaves x alone; the SPAWN cycle produces the strobe.
              if (obstacles_x <= speed) begin
                if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
                state <= SPAWN;
              end else begin
                obstacles_x <= obstacles_x - speed;
                check_en    <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed self-checking bench for obstacle_scroller with hand-computed expectations.
module tb_obstacle_scroller;

  logic       clk = 1'b0;
  logic       reset, start, stop, freeze, frame_tick;
  logic [7:0] obstacles_x;
  logic [6:0] obstacles_y;
  logic [7:0] height;
  logic [4:0] width;
  logic       check_en, obstacle_valid;
  logic [7:0] pass_count;

  int checks = 0;
  int errors = 0;
  int pulses;

  obstacle_scroller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .freeze(freeze),
    .frame_tick(frame_tick), .obstacles_x(obstacles_x), .obstacles_y(obstacles_y),
    .height(height), .width(width), .check_en(check_en),
    .obstacle_valid(obstacle_valid), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x"}, obstacles_x, 159);
    check_eq({tag, "_y"}, obstacles_y, 8);
    check_eq({tag, "_h"}, height, 40);
    check_eq({tag, "_w"}, width, 12);
    check_eq({tag, "_chk"}, check_en, 0);
    check_eq({tag, "_vld"}, obstacle_valid, 0);
    check_eq({tag, "_pass"}, pass_count, 0);
  endtask

  // Holds frame_tick high until obstacles_x hits target or pass_count hits target_pass.
  task automatic run_until(input int target_x, input int target_pass, input string tag);
    int n;
    n = 0;
    frame_tick = 1'b1;
    while (obstacles_x != target_x && pass_count != target_pass && n < 20000) begin
      step();
      n++;
    end
    frame_tick = 1'b0;
    if (n >= 20000) check_eq({tag, "_timeout"}, n, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; freeze = 1'b0; frame_tick = 1'b0;
    step(); step();
    check_reset_vals("rst");
    reset = 1'b0;

    // start -> SPAWN -> loaded coordinates with one strobe
    start = 1'b1; step(); start = 1'b0;
    check_eq("spawn_cycle_chk", check_en, 0);
    check_eq("spawn_cycle_vld", obstacle_valid, 0);
    step();
    check_eq("spawn_x", obstacles_x, 159);
    check_eq("spawn_y", obstacles_y, 45);
    check_eq("spawn_h", height, 40);
    check_eq("spawn_w", width, 12);
    check_eq("spawn_vld", obstacle_valid, 1);
    check_eq("spawn_chk", check_en, 1);
    step();
    check_eq("spawn_chk_one", check_en, 0);

    // 10 ticks, 4 cycles apart
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      check_eq("tick_chk", check_en, 1);
      check_eq("tick_x", obstacles_x, 158 - i);
      if (check_en) pulses++;
      for (int k = 0; k < 3; k++) begin
        step();
        if (check_en) pulses++;
      end
    end
    check_eq("ten_ticks_x", obstacles_x, 149);
    check_eq("ten_ticks_pulses", pulses, 10);

    // scroll to x = 1, then the respawn tick
    run_until(1, 256, "scroll");
    check_eq("edge_x", obstacles_x, 1);
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("respawn_tick_chk", check_en, 0);
    check_eq("respawn_tick_x", obstacles_x, 1);
    check_eq("respawn_pass", pass_count, 1);
    step();
    check_eq("respawn_x", obstacles_x, 159);
    check_eq("respawn_y", obstacles_y, 18);
    check_eq("respawn_chk", check_en, 1);
    check_eq("respawn_pass2", pass_count, 1);
    step();

    // freeze drops ticks
    freeze = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      if (check_en) pulses++;
      step();
      if (check_en) pulses++;
    end
    check_eq("freeze_pulses", pulses, 0);
    check_eq("freeze_x", obstacles_x, 159);
    check_eq("freeze_y", obstacles_y, 18);
    check_eq("freeze_pass", pass_count, 1);
    freeze = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("unfreeze_x", obstacles_x, 158);
    check_eq("unfreeze_chk", check_en, 1);
    step();

    // start while moving is ignored
    start = 1'b1; step(); start = 1'b0;
    check_eq("start_in_move_chk", check_en, 0);
    check_eq("start_in_move_x", obstacles_x, 158);
    check_eq("start_in_move_pass", pass_count, 1);

    // stop beats frame_tick
    frame_tick = 1'b1; stop = 1'b1; step(); frame_tick = 1'b0; stop = 1'b0;
    check_eq("stop_vld", obstacle_valid, 0);
    check_eq("stop_chk", check_en, 0);
    check_eq("stop_x", obstacles_x, 158);
    check_eq("stop_pass_kept", pass_count, 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("idle_tick_x", obstacles_x, 158);
    check_eq("idle_tick_chk", check_en, 0);

    // restart: pass_count clears, LFSR continues (0x4A -> 0x95)
    start = 1'b1; step(); start = 1'b0;
    check_eq("restart_pass", pass_count, 0);
    step();
    check_eq("restart_x", obstacles_x, 159);
    check_eq("restart_y", obstacles_y, 29);
    check_eq("restart_vld", obstacle_valid, 1);
    step();

`ifdef DIFFICULTY_RAMP_EN
    run_until(256, 8, "ramp8");
    step();
    check_eq("ramp8_h", height, 38);
    check_eq("ramp8_x", obstacles_x, 159);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("ramp8_step", obstacles_x, 157);
    run_until(256, 24, "ramp24");
    step();
    check_eq("ramp24_h", height, 34);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("ramp24_step", obstacles_x, 155);
    run_until(256, 32, "ramp32");
    step();
    check_eq("ramp32_h", height, 34);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("ramp32_step", obstacles_x, 155);
    step();
`endif

    // reset mid-MOVE
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("pre_reset_chk", check_en, 1);
    reset = 1'b1; step(); reset = 1'b0;
    check_reset_vals("midrst");
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("post_reset_idle_x", obstacles_x, 159);
    check_eq("post_reset_idle_chk", check_en, 0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check_eq("reseed_y", obstacles_y, 45);
    check_eq("reseed_chk", check_en, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
